// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port-A arbiter: owner encoding and read-return tag.
// No logic and no latency; pure type and default-width definitions.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundles both master request/response channels and the RAM port-A signals.
// slave = arbiter side, master = requesters and the RAM model.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rvalid, m1_rdata,
        output ram_addr, ram_data, ram_wren,
        input  ram_q
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rvalid, m1_rdata,
        input  ram_addr, ram_data, ram_wren,
        output ram_q
    );

endinterface

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// Delays the issue tag by READ_LATENCY clocks so it lines up with ram_q.
// No backpressure: one tag enters and one leaves every clock; clear flushes all stages.
module ram_rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic    clock,
    input  logic    clear,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage [READ_LATENCY];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[READ_LATENCY-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares RAM port A between M0 (CPU) and M1 (fill engine): one access per clock, ack same cycle.
// Read data returns READ_LATENCY clocks after ack; a loser simply keeps req high until acked.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 1,
    parameter int FIXED_PRIO   = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clock,
    input  logic            clear,
    ram_port_arbiter_if.slave bus
);

    localparam int SC_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    owner_t            last_grant;
    logic [SC_W-1:0]   starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic              gnt0;
    logic              gnt1;
    logic              any_gnt;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    rd_tag_t           tag_issue;
    rd_tag_t           tag_ret;

    // Grants are suppressed during clear so no access can leak out of reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!clear) begin
            if (bus.m0_req && bus.m1_req) begin
                if (FIXED_PRIO != 0) begin
                    if (starve_cnt == STARVE_MAX) begin
                        gnt1 = 1'b1;
                    end else begin
                        gnt0 = 1'b1;
                    end
                end else if (last_grant == OWN_M1) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else if (bus.m0_req) begin
                gnt0 = 1'b1;
            end else if (bus.m1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        any_gnt  = gnt0 | gnt1;
        win_we   = 1'b0;
        win_addr = addr_q;
        win_data = data_q;
        if (gnt0) begin
            win_we   = bus.m0_we;
            win_addr = bus.m0_addr;
            win_data = bus.m0_wdata;
        end else if (gnt1) begin
            win_we   = bus.m1_we;
            win_addr = bus.m1_addr;
            win_data = bus.m1_wdata;
        end
    end

    assign bus.m0_ack   = gnt0;
    assign bus.m1_ack   = gnt1;
    assign bus.ram_wren = win_we;
    assign bus.ram_addr = win_addr;
    assign bus.ram_data = win_data;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            last_grant <= OWN_M1;
            starve_cnt <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            if (gnt0) begin
                last_grant <= OWN_M0;
            end else if (gnt1) begin
                last_grant <= OWN_M1;
            end

            if (!bus.m1_req || gnt1) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (any_gnt) begin
                addr_q <= win_addr;
                data_q <= win_data;
            end
        end
    end

    // Writes still push a tag (valid=0) so the pipe advances uniformly.
    always_comb begin
        tag_issue.valid = any_gnt & ~win_we;
        tag_issue.owner = gnt1 ? OWN_M1 : OWN_M0;
    end

    ram_rd_tag_pipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_tag_pipe (
        .clock  (clock),
        .clear  (clear),
        .tag_in (tag_issue),
        .tag_out(tag_ret)
    );

    assign bus.m0_rvalid = tag_ret.valid && (tag_ret.owner == OWN_M0);
    assign bus.m1_rvalid = tag_ret.valid && (tag_ret.owner == OWN_M1);
    assign bus.m0_rdata  = bus.ram_q;
    assign bus.m1_rdata  = bus.ram_q;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares port A of the 16-bit dual-port main RAM between two masters: M0 (CPU core) and M1 (framebuffer fill/copy engine). Port B stays dedicated to the VGA scanout.
- Issues at most one RAM access per clock.
- Uses a round-robin or starvation-bounded fixed-priority policy.
- Routes read data back to the master that issued the read, using a tag pipeline matched to the RAM read latency.

Parameters:
ADDR_W, 16, RAM word-address width
DATA_W, 16, RAM data width
READ_LATENCY, 1, clocks from address edge to valid ram_q (1..3)
FIXED_PRIO, 0, 0 = round-robin; 1 = M0 has priority, bounded by STARVE_LIMIT
STARVE_LIMIT, 8, in FIXED_PRIO mode, the number of consecutive denied cycles after which M1 is force-granted (>=1)

Ports:
clock  in  1  system clock (50 MHz domain shared with the RAM)
clear  in  1  reset, asynchronous, active-high
m0_req  in  1  M0 request; held with stable fields until m0_ack
m0_we  in  1  M0 write enable
m0_addr  in  ADDR_W  M0 address
m0_wdata  in  DATA_W  M0 write data
m0_ack  out  1  M0 access issued this cycle
m0_rvalid  out  1  M0 read data valid
m0_rdata  out  DATA_W  M0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rvalid, m1_rdata: same as M0, for M1
ram_addr  out  ADDR_W  to RAM address_a
ram_data  out  DATA_W  to RAM data_a
ram_wren  out  1  to RAM wren_a
ram_q  in  DATA_W  from RAM q_a

Behaviour:
Reset
- While clear=1: m0_ack, m1_ack, ram_wren, m0_rvalid and m1_rvalid are all 0.
- Also on clear: tag pipeline is flushed, last_grant=M1 (so M0 wins the first contested cycle), starve_cnt=0.
- clear during an in-flight read: the result is dropped and no rvalid is produced.

Arbitration (combinational within cycle t; state updates at the edge)
- Only one requester: it wins.
- Round-robin, both requesting: the master other than last_grant wins.
- FIXED_PRIO=1, both requesting: M0 wins unless starve_cnt==STARVE_LIMIT, in which case M1 wins.
- starve_cnt:
  - increments when m1_req=1 and M1 loses;
  - resets to 0 when M1 is granted or m1_req=0;
  - saturates at STARVE_LIMIT.
- last_grant updates only on a grant.
- No request: ram_wren=0; ram_addr/ram_data hold their last value.

Issue
- Winner's addr/wdata/we drive ram_addr/ram_data/ram_wren in cycle t.
- Winner's ack=1 in cycle t only. The master may change fields or drop req after that edge.
- ack is never asserted without req. At most one ack per cycle.

Read return
- A read issued in cycle t pushes a tag {valid=1, owner} into a READ_LATENCY-deep shift register.
- The stage READ_LATENCY output drives mX_rvalid, which is 1 for exactly one cycle at t+READ_LATENCY for the owner.
- mX_rdata = ram_q for both masters; it is meaningful only when the matching rvalid=1.
- Writes push a tag with valid=0.
- Back-to-back reads (one per cycle, either master) return in issue order with no bubbles.

Write/read ordering
- The RAM port is in-order, so a read issued after a write to the same address returns the new data. The arbiter adds no forwarding.

Decomposition:
- Package ram_arb_pkg:
  - ADDR_W/DATA_W defaults;
  - typedef enum owner_t {OWN_M0, OWN_M1};
  - packed struct rd_tag_t {valid, owner_t owner}.
- Sub-module ram_rd_tag_pipe: parameterised READ_LATENCY shift register of rd_tag_t with async clear. Input is the issue tag; output is the return tag.

Test Plan:
- M0 write 0x1234 to 0x0040, then M0 read 0x0040 -> m0_ack one cycle each; m0_rvalid=1 with m0_rdata=0x1234 exactly READ_LATENCY cycles after the read ack; m1_rvalid stays 0.
- FIXED_PRIO=0, both masters hold read requests for 6 cycles -> acks alternate M0,M1,M0,M1,M0,M1; rvalid returns in the same alternating order, each with the correct address's data.
- FIXED_PRIO=1, STARVE_LIMIT=3, both requesting continuously -> grant pattern M0,M0,M0,M1 repeating; starve_cnt never exceeds 3.
- READ_LATENCY=2, M1 issues reads to 0x0000..0x0003 back-to-back, with preloaded data 0xA0..0xA3 -> m1_rvalid high for 4 consecutive cycles starting 2 cycles after the first ack, with data 0xA0,0xA1,0xA2,0xA3.
- Assert clear for one cycle, 0 cycles after an M0 read ack -> no m0_rvalid ever appears for that read; the next contested cycle grants M0.
- No requests for 5 cycles -> ram_wren=0, no acks, no rvalids; ram_addr unchanged.
